// File: rtl/vmicro16_soc.sv
// vmicro16_soc: multi-core summation SoC.
// Worker cores sum memory slices; an arbiter merges the partial sums.
module vmicro16_soc #(
   parameter int CORES      = 4,
   parameter int ELEMENTS   = 240,
   parameter int DATA_WIDTH = 16,
   parameter int GPIO1_PINS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  halt,
   output logic [GPIO1_PINS-1:0] gpio1
);

   localparam int S  = ELEMENTS / CORES;
   localparam int AW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
   localparam int IW = $clog2(S + 1);

   typedef enum logic [1:0] {
      C_FETCH,
      C_REQ,
      C_DONE
   } core_t;

   typedef enum logic [1:0] {
      T_RUN,
      T_PUBLISH,
      T_HALT
   } top_t;

   logic [DATA_WIDTH-1:0] mem [ELEMENTS];

   core_t                 cstate [CORES];
   logic [IW-1:0]         idx    [CORES];
   logic                  rvalid [CORES];
   logic [DATA_WIDTH-1:0] rdata  [CORES];
   logic [DATA_WIDTH-1:0] sum    [CORES];

   logic [CORES-1:0]      gnt;
   logic [DATA_WIDTH-1:0] gnt_sum;
   logic                  fin;

   logic [DATA_WIDTH-1:0] acc;
   top_t                  tstate;

   // read-only data memory: word i holds i modulo 2^DATA_WIDTH
   for (genvar i = 0; i < ELEMENTS; i++) begin : g_mem
      assign mem[i] = DATA_WIDTH'(i);
   end

   function automatic logic [AW-1:0] addr_of(input int k,
                                             input logic [IW-1:0] i);
      return AW'(k * S) + AW'(i);
   endfunction

   // fixed-priority grant; fin is set when this edge leaves every core done
   always_comb begin
      gnt     = '0;
      gnt_sum = '0;
      fin     = 1'b1;
      for (int k = 0; k < CORES; k++) begin
         if (cstate[k] == C_REQ && gnt == '0) begin
            gnt[k]  = 1'b1;
            gnt_sum = sum[k];
         end
         if (cstate[k] != C_DONE && !gnt[k]) begin
            fin = 1'b0;
         end
      end
   end

   // per-core fetch/accumulate/request state machines
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < CORES; k++) begin
            cstate[k] <= C_FETCH;
            idx[k]    <= '0;
            rvalid[k] <= 1'b0;
            rdata[k]  <= '0;
            sum[k]    <= '0;
         end
      end else begin
         for (int k = 0; k < CORES; k++) begin
            unique case (cstate[k])
               C_FETCH: begin
                  if (idx[k] != IW'(S)) begin
                     rdata[k]  <= mem[addr_of(k, idx[k])];
                     rvalid[k] <= 1'b1;
                     idx[k]    <= idx[k] + 1'b1;
                  end else begin
                     rvalid[k] <= 1'b0;
                  end
                  if (rvalid[k]) begin
                     sum[k] <= sum[k] + rdata[k];
                     if (idx[k] == IW'(S)) begin
                        cstate[k] <= C_REQ;
                     end
                  end
               end
               C_REQ: begin
                  if (gnt[k]) begin
                     cstate[k] <= C_DONE;
                  end
               end
               C_DONE: begin
               end
               default: begin
                  cstate[k] <= C_FETCH;
               end
            endcase
         end
      end
   end

   // merge granted sums, then publish the result and halt
   always_ff @(posedge clk) begin
      if (reset) begin
         tstate <= T_RUN;
         acc    <= '0;
         gpio1  <= '0;
         halt   <= 1'b0;
      end else begin
         unique case (tstate)
            T_RUN: begin
               if (gnt != '0) begin
                  acc <= acc + gnt_sum;
               end
               if (fin) begin
                  tstate <= T_PUBLISH;
               end
            end
            T_PUBLISH: begin
               gpio1  <= GPIO1_PINS'(acc);
               tstate <= T_HALT;
            end
            T_HALT: begin
               halt <= 1'b1;
            end
            default: begin
               tstate <= T_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vmicro16_soc.sv
// tb_vmicro16_soc: checks four SoC configurations side by side.
// Expected sums and halt timing come from a plain arithmetic model.
module tb_vmicro16_soc;

   localparam int N = 4;

   typedef struct {
      int          cores;
      int          elements;
      logic [15:0] exp_gpio;
   } cfg_t;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [N-1:0]         hv;
   logic [N-1:0][15:0]   gv;

   cfg_t        tbl [N];
   logic [15:0] model_sum [N];
   int          model_halt [N];

   int pass_cnt = 0;
   int total    = 0;
   int limit    = 0;

   always #5 clk = ~clk;

   vmicro16_soc #(.CORES(4), .ELEMENTS(240)) u0 (
      .clk(clk), .reset(reset), .halt(hv[0]), .gpio1(gv[0]));
   vmicro16_soc #(.CORES(1), .ELEMENTS(240)) u1 (
      .clk(clk), .reset(reset), .halt(hv[1]), .gpio1(gv[1]));
   vmicro16_soc #(.CORES(2), .ELEMENTS(8)) u2 (
      .clk(clk), .reset(reset), .halt(hv[2]), .gpio1(gv[2]));
   vmicro16_soc #(.CORES(4), .ELEMENTS(512)) u3 (
      .clk(clk), .reset(reset), .halt(hv[3]), .gpio1(gv[3]));

   // sum of mem[i] = i mod 2^16, wrapped to 16 bits
   function automatic logic [15:0] ref_sum(input int elements);
      logic [31:0] s;
      s = 0;
      for (int i = 0; i < elements; i++) s += 32'(i % 65536);
      return s[15:0];
   endfunction

   // each core needs S cycles of fetch, then one grant per core,
   // then one cycle to publish and one to raise halt
   function automatic int ref_halt(input cfg_t c);
      return c.elements / c.cores + c.cores + 2;
   endfunction

   task automatic check(input string name, input int k,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s dut%0d actual=%0h required=%0h",
                    name, k, act, exp);
   endtask

   // hold reset n edges, check cleared outputs, release before next edge
   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         check("reset_halt", k, 32'(hv[k]), 32'd0);
         check("reset_gpio", k, 32'(gv[k]), 32'd0);
      end
      reset = 1'b0;
   endtask

   // run from release (next edge is edge 0) until 100 cycles past halt
   task automatic run_full(input string tag);
      int bad_e [N];
      logic [15:0] bad_g [N];
      logic bad_h [N];
      logic [15:0] eg [N];
      logic eh [N];
      for (int k = 0; k < N; k++) begin
         bad_e[k] = -1;
         bad_g[k] = '0;
         bad_h[k] = 1'b0;
         eg[k] = '0;
         eh[k] = 1'b0;
      end
      for (int e = 0; e <= limit; e++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            eh[k] = (e >= model_halt[k]);
            eg[k] = (e >= model_halt[k] - 1) ? model_sum[k] : 16'h0;
            if (bad_e[k] < 0 && (hv[k] !== eh[k] || gv[k] !== eg[k])) begin
               bad_e[k] = e;
               bad_g[k] = gv[k];
               bad_h[k] = hv[k];
            end
            if (e == model_halt[k] - 1)
               check({tag, "_halt_not_early"}, k, 32'(hv[k]), 32'd0);
            if (e == model_halt[k]) begin
               check({tag, "_gpio_at_halt"}, k, 32'(gv[k]),
                     32'(tbl[k].exp_gpio));
               check({tag, "_halt_edge"}, k, 32'(hv[k]), 32'd1);
            end
         end
      end
      for (int k = 0; k < N; k++) begin
         total++;
         if (bad_e[k] < 0) pass_cnt++;
         else $display("FAIL %s_monitor dut%0d edge=%0d actual halt=%0b gpio=%h required halt=%0b gpio=%h",
                       tag, k, bad_e[k], bad_h[k], bad_g[k],
                       (bad_e[k] >= model_halt[k]),
                       (bad_e[k] >= model_halt[k] - 1) ? model_sum[k] : 16'h0);
      end
   endtask

   initial begin
      int cyc;
      int len;
      tbl[0] = '{cores: 4, elements: 240, exp_gpio: 16'h7008};
      tbl[1] = '{cores: 1, elements: 240, exp_gpio: 16'h7008};
      tbl[2] = '{cores: 2, elements: 8,   exp_gpio: 16'h001C};
      tbl[3] = '{cores: 4, elements: 512, exp_gpio: 16'hFF00};
      for (int k = 0; k < N; k++) begin
         model_sum[k]  = ref_sum(tbl[k].elements);
         model_halt[k] = ref_halt(tbl[k]);
         if (model_halt[k] + 100 > limit) limit = model_halt[k] + 100;
      end

      apply_reset(4);
      run_full("base");
      if (gv[0] === 16'h7008 && hv[0] === 1'b1) $display("SUCCESS");

      apply_reset(2);
      repeat (31) @(posedge clk);
      #1;
      apply_reset(2);
      run_full("restart30");

      for (int t = 0; t < 3; t++) begin
         cyc = $urandom_range(0, 300);
         len = $urandom_range(1, 4);
         apply_reset(1);
         repeat (cyc + 1) @(posedge clk);
         #1;
         apply_reset(len);
         run_full($sformatf("rnd%0d", t));
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
